divider_iter: RTL and testbench

- Parametrised iterative integer divider for the RISC-V M extension: DIV, DIVU, REM, REMU.
- Owns its subtractor and needs no ALU sharing; retires STEPS bits per cycle.
- Uses valid/ready on both sides and supports a pipeline kill.
- Sits beside the multiplier in the execute stage and writes result_o to the regfile path.

---
 rtl/libalu.sv | 28 ++
 rtl/divider_iter_div_step.sv | 24 ++
 rtl/divider_iter.sv | 169 ++++++++++++++++
 tb/tb_divider_iter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/libalu.sv
// Shared ALU definitions: M-extension funct3 encodings, divider state type,
// and small decode helpers used by the execute-stage arithmetic blocks.
package libalu;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

    // Signed ops are DIV and REM; any unknown encoding behaves as REMU.
    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Quotient is returned for DIV/DIVU; everything else returns a remainder.
    function automatic logic is_quot_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU);
    endfunction

endpackage

// File: rtl/divider_iter_div_step.sv
// One restoring-division step: shift [rem|quo] left by one, trial-subtract
// the divisor from the upper part, keep or restore, and shift in the
// quotient bit. Purely combinational so several can be chained per cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so shifted < 2*divisor and a WIDTH+1 bit
    // difference is enough: its top bit is set exactly when the trial fails.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/divider_iter.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU), STEPS quotient
// bits per cycle, valid/ready on both sides, pipeline kill.
// Optional: define DIVIDER_ITER_EARLY_OUT_EN to finish in PREP when
// |a| < |b| (results are identical, only latency changes).
module divider_iter
    import libalu::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             div_zero_o
);

    localparam int N  = WIDTH / STEPS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] a_q, b_q, divisor_q;
    logic [WIDTH-1:0] rem_q, quo_q, result_q;
    logic             q_neg_q, r_neg_q, div_zero_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, sgn, a_neg, b_neg, b_zero, ovf, early;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

    assign in_ready_o  = (state_q == ST_IDLE) && !kill_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign result_o    = result_q;
    assign div_zero_o  = div_zero_q;

    // Operand preparation on the latched request.
    assign sgn    = is_signed_op(f3_q);
    assign a_neg  = sgn && a_q[WIDTH-1];
    assign b_neg  = sgn && b_q[WIDTH-1];
    assign a_abs  = a_neg ? -a_q : a_q;
    assign b_abs  = b_neg ? -b_q : b_q;
    assign b_zero = (b_q == '0);
    assign ovf    = sgn && (a_q == MIN_NEG) && (b_q == '1);
`ifdef DIVIDER_ITER_EARLY_OUT_EN
    assign early  = !b_zero && (a_abs < b_abs);
`else
    assign early  = 1'b0;
`endif

    // Sign correction and result selection used in FIX.
    assign q_fix = q_neg_q ? -quo_q : quo_q;
    assign r_fix = r_neg_q ? -rem_q : rem_q;

    logic [WIDTH-1:0] rem_chain [STEPS+1];
    logic [WIDTH-1:0] quo_chain [STEPS+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem      (rem_chain[g]),
            .quo      (quo_chain[g]),
            .divisor  (divisor_q),
            .rem_next (rem_chain[g+1]),
            .quo_next (quo_chain[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset -- rst is only looked at on the clock edge,
        // and sequential state uses non-blocking assignments so every
        // register samples the pre-edge values.
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; kill overrides every transition out of a busy state.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_PREP;
            ST_PREP: state_d = (b_zero || ovf || early) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CW'(N-1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Datapath: latch request, set up operands, iterate, fix signs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            f3_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q       <= funct3_i;
                        a_q        <= a_i;
                        b_q        <= b_i;
                        div_zero_q <= 1'b0;
                    end
                end
                ST_PREP: begin
                    if (b_zero) begin
                        quo_q      <= '1;
                        rem_q      <= a_q;
                        q_neg_q    <= 1'b0;
                        r_neg_q    <= 1'b0;
                        div_zero_q <= 1'b1;
                    end else if (ovf) begin
                        quo_q   <= a_q;
                        rem_q   <= '0;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                    end else if (early) begin
                        quo_q   <= '0;
                        rem_q   <= a_abs;
                        q_neg_q <= 1'b0;
                        r_neg_q <= a_neg;
                    end else begin
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        divisor_q <= b_abs;
                        q_neg_q   <= a_neg ^ b_neg;
                        r_neg_q   <= a_neg;
                        cnt_q     <= '0;
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_chain[STEPS];
                    quo_q <= quo_chain[STEPS];
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_FIX: begin
                    result_q <= is_quot_op(f3_q) ? q_fix : r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: two instances (STEPS=1 and STEPS=4)
// share the request bus; a scoreboard queue holds expected result, divide-
// by-zero flag and latency, popped when the selected instance responds.
module tb_divider_iter;
    import libalu::*;

    localparam int W = 32;
`ifdef DIVIDER_ITER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   funct3 = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0]   in_valid = '0;
    logic [1:0]   ov_v, rdy_v, busy_v, dz_v;
    logic [W-1:0] res_v [2];

    int           sel = 0;
    logic         ov, rdy, busy, dz;
    logic [W-1:0] res;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    divider_iter #(.WIDTH(W), .STEPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid[0]), .in_ready_o(rdy_v[0]),
        .funct3_i(funct3), .a_i(a), .b_i(b), .kill_i(kill),
        .out_valid_o(ov_v[0]), .out_ready_i(out_ready), .result_o(res_v[0]),
        .busy_o(busy_v[0]), .div_zero_o(dz_v[0])
    );

    divider_iter #(.WIDTH(W), .STEPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid[1]), .in_ready_o(rdy_v[1]),
        .funct3_i(funct3), .a_i(a), .b_i(b), .kill_i(kill),
        .out_valid_o(ov_v[1]), .out_ready_i(out_ready), .result_o(res_v[1]),
        .busy_o(busy_v[1]), .div_zero_o(dz_v[1])
    );

    always_comb begin
        ov   = ov_v[sel];
        rdy  = rdy_v[sel];
        busy = busy_v[sel];
        dz   = dz_v[sel];
        res  = res_v[sel];
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int full_lat(input int s);
        return (W / s) + 2;
    endfunction

    // Reference model: RISC-V division semantics plus expected latency.
    function automatic exp_t model(input logic [2:0] f3, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int s);
        exp_t e;
        logic signed [W-1:0] sx, sy;
        logic [W-1:0] q, r, mx, my;
        logic sg;
        sg = (f3 == F3_DIV) || (f3 == F3_REM);
        sx = x;
        sy = y;
        mx = (sg && x[W-1]) ? -x : x;
        my = (sg && y[W-1]) ? -y : y;
        e.dz  = 1'b0;
        e.lat = full_lat(s);
        if (y == '0) begin
            q = '1; r = x; e.dz = 1'b1; e.lat = 2;
        end else if (sg && x == 32'h8000_0000 && y == '1) begin
            q = x; r = '0; e.lat = 2;
        end else begin
            if (sg) begin q = sx / sy; r = sx % sy; end
            else    begin q = x / y;   r = x % y;   end
            if (EARLY && mx < my) e.lat = 2;
        end
        e.res = ((f3 == F3_DIV) || (f3 == F3_DIVU)) ? q : r;
        return e;
    endfunction

    task automatic drive_accept(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        while (!rdy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rdy) check("ready_timeout", {31'b0, rdy}, 32'd1);
        funct3 = f3;
        a = x;
        b = y;
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid = '0;
        a = $urandom;
        b = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ov && lat < 200);
        if (!ov) check("out_timeout", {31'b0, ov}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e);
        exp_t got_e;
        int lat;
        sb.push_back(e);
        drive_accept(f3, x, y);
        wait_out(lat);
        got_e = sb.pop_front();
        check({tag, "/res"}, res, got_e.res);
        check({tag, "/dz"}, {31'b0, dz}, {31'b0, got_e.dz});
        check({tag, "/lat"}, lat, got_e.lat);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic z, input int l);
        exp_t e;
        e.res = r; e.dz = z; e.lat = l;
        return e;
    endfunction

    initial begin
        int lat, seen;
        exp_t e;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            sel = d; #0;
            check($sformatf("rst%0d/ov", d), {31'b0, ov}, 32'd0);
            check($sformatf("rst%0d/busy", d), {31'b0, busy}, 32'd0);
            check($sformatf("rst%0d/res", d), res, 32'd0);
            check($sformatf("rst%0d/dz", d), {31'b0, dz}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            sel = d; #0;
            check($sformatf("idle%0d/rdy", d), {31'b0, rdy}, 32'd1);
        end

        // Directed operations on the one-bit-per-cycle instance.
        sel = 0;
        run_op("div_m7_2",   F3_DIV,  32'hFFFF_FFF9, 32'd2,        mk(32'hFFFF_FFFD, 1'b0, 34));
        run_op("rem_m7_2",   F3_REM,  32'hFFFF_FFF9, 32'd2,        mk(32'hFFFF_FFFF, 1'b0, 34));
        run_op("divu_by0",   F3_DIVU, 32'hFFFF_FFFF, 32'd0,        mk(32'hFFFF_FFFF, 1'b1, 2));
        run_op("remu_by0",   F3_REMU, 32'hFFFF_FFFF, 32'd0,        mk(32'hFFFF_FFFF, 1'b1, 2));
        run_op("rem_5_by0",  F3_REM,  32'd5,         32'd0,        mk(32'd5,         1'b1, 2));
        run_op("div_ovf",    F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 1'b0, 2));
        run_op("rem_ovf",    F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0,         1'b0, 2));
        run_op("divu_3_9",   F3_DIVU, 32'd3,         32'd9,        mk(32'd0, 1'b0, EARLY ? 2 : 34));
        run_op("remu_3_9",   F3_REMU, 32'd3,         32'd9,        mk(32'd3, 1'b0, EARLY ? 2 : 34));
        run_op("rem_m5_3",   F3_REM,  32'hFFFF_FFFB, 32'd3,        mk(32'hFFFF_FFFE, 1'b0, 34));
        run_op("bad_f3",     3'b010,  32'd100,       32'd7,        mk(32'd2, 1'b0, 34));

        // Kill in CALC cycle 10, then a clean DIVU 20/3.
        drive_accept(F3_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_calc/busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov) seen++;
        end
        check("kill_calc/no_out", seen, 32'd0);
        run_op("divu_20_3", F3_DIVU, 32'd20, 32'd3, mk(32'd6, 1'b0, 34));

        // Kill while IDLE blocks acceptance.
        kill = 1'b1; #1;
        check("kill_idle/rdy", {31'b0, rdy}, 32'd0);
        funct3 = F3_DIVU; a = 32'd9; b = 32'd3;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid = '0;
        kill = 1'b0;
        check("kill_idle/busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation drops the op and clears result.
        drive_accept(F3_DIVU, 32'd77, 32'd5);
        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst_mid/busy", {31'b0, busy}, 32'd0);
        check("rst_mid/res", res, 32'd0);

        // Four-bit-per-cycle instance: latency and back-pressure.
        sel = 1;
        out_ready = 1'b0;
        sb.push_back(mk(32'd2, 1'b0, 10));
        drive_accept(F3_REMU, 32'd100, 32'd7);
        wait_out(lat);
        e = sb.pop_front();
        check("s4_remu/lat", lat, e.lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("s4_stall/res", res, e.res);
            check("s4_stall/ov", {31'b0, ov}, 32'd1);
            check("s4_stall/rdy", {31'b0, rdy}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("s4_release/ov", {31'b0, ov}, 32'd0);

        // Kill in DONE has priority over out_ready.
        out_ready = 1'b0;
        sb.push_back(mk(32'hFFFF_FFFA, 1'b0, 10));
        drive_accept(F3_DIV, 32'd30, 32'hFFFF_FFFB);
        wait_out(lat);
        e = sb.pop_front();
        check("s4_kdone/res", res, e.res);
        kill = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("s4_kdone/ov", {31'b0, ov}, 32'd0);
        check("s4_kdone/busy", {31'b0, busy}, 32'd0);

        // Random traffic on both instances against the model.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int i = 0; i < 15; i++) begin
                logic [2:0]   f3r;
                logic [W-1:0] xr, yr;
                f3r = 3'($urandom_range(0, 7));
                xr  = $urandom;
                case ($urandom_range(0, 4))
                    0:       yr = $urandom;
                    1:       yr = 32'($urandom_range(1, 20));
                    2:       yr = 32'd0;
                    3:       begin xr = 32'($urandom_range(0, 50)); yr = $urandom; end
                    default: yr = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                endcase
                run_op($sformatf("rnd%0d_%0d", d, i), f3r, xr, yr, model(f3r, xr, yr, d == 0 ? 1 : 4));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
